// File: rtl/cpu64_inst_aligner.sv
// Fetch-side instruction aligner: splits 32-bit fetch words into 16-bit
// parcels, reassembles 16/32-bit instructions (including ones straddling a
// fetch word) and presents one instruction per cycle with its PC.
module cpu64_inst_aligner #(
  parameter int unsigned        VADDR    = 39,
  parameter logic [VADDR-1:0]   RESET_PC = 'h80000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             fetch_valid_i,
  input  logic [31:0]      fetch_data_i,
  output logic             fetch_ready_o,
  input  logic             flush_i,
  input  logic [VADDR-1:0] flush_pc_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [31:0]      inst_o,
  output logic [VADDR-1:0] inst_pc_o,
  output logic             inst_compressed_o
);

  // Anything other than 2'b11 in the low bits is an RVC encoding.
  function automatic logic is_compressed(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

  // Compressed instructions are zero-extended; 48-bit and longer encodings
  // are passed on as 32-bit and flagged illegal by decode.
  function automatic logic [31:0] form_inst(input logic [15:0] p0,
                                            input logic [15:0] p1,
                                            input logic        comp);
    return comp ? {16'h0000, p0} : {p1, p0};
  endfunction

  // Stage p0: parcel queue, head PC and half-word skip flag.
  logic [15:0]      parcel_p0 [3];
  logic [1:0]       count_p0;
  logic [VADDR-1:0] head_pc_p0;
  logic             skip_lo_p0;

  // Stage p1: output register towards decode.
  logic             vld_p1;
  logic [31:0]      inst_p1;
  logic [VADDR-1:0] pc_p1;
  logic             comp_p1;

  logic             head_comp;
  logic             take;
  logic [1:0]       ext_len;
  logic [1:0]       surv;
  logic             accept;
  logic [15:0]      parcel_nxt [3];
  logic [1:0]       count_nxt;

  // Decide how many head parcels leave the queue this cycle.
  always_comb begin
    head_comp = is_compressed(parcel_p0[0]);
    take      = !vld_p1 || inst_ready_i;
    ext_len   = 2'd0;
    if (take) begin
      if (head_comp && (count_p0 >= 2'd1)) begin
        ext_len = 2'd1;
      end else if (!head_comp && (count_p0 >= 2'd2)) begin
        ext_len = 2'd2;
      end
    end
    surv = count_p0 - ext_len;
  end

  // A word always fits when at most one parcel survives this cycle.
  assign fetch_ready_o = !flush_i && (surv <= 2'd1);
  assign accept        = fetch_valid_i && fetch_ready_o;

  // Shift survivors to the head, then append the new parcels behind them.
  always_comb begin
    parcel_nxt = parcel_p0;
    count_nxt  = surv;
    case (ext_len)
      2'd1: begin
        parcel_nxt[0] = parcel_p0[1];
        parcel_nxt[1] = parcel_p0[2];
      end
      2'd2: parcel_nxt[0] = parcel_p0[2];
      default: ;
    endcase
    if (accept) begin
      if (skip_lo_p0) begin
        if (surv == 2'd0) parcel_nxt[0] = fetch_data_i[31:16];
        else              parcel_nxt[1] = fetch_data_i[31:16];
        count_nxt = surv + 2'd1;
      end else begin
        if (surv == 2'd0) begin
          parcel_nxt[0] = fetch_data_i[15:0];
          parcel_nxt[1] = fetch_data_i[31:16];
        end else begin
          parcel_nxt[1] = fetch_data_i[15:0];
          parcel_nxt[2] = fetch_data_i[31:16];
        end
        count_nxt = surv + 2'd2;
      end
    end
  end

  // Parcel storage; entries beyond count are don't-care so no reset needed.
  always_ff @(posedge clk_i) begin
    parcel_p0 <= parcel_nxt;
  end

  // Queue control, head PC and the output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_p0   <= 2'd0;
      head_pc_p0 <= RESET_PC;
      skip_lo_p0 <= RESET_PC[1];
      vld_p1     <= 1'b0;
      inst_p1    <= 32'h0;
      pc_p1      <= '0;
      comp_p1    <= 1'b0;
    end else if (flush_i) begin
      count_p0   <= 2'd0;
      head_pc_p0 <= flush_pc_i;
      skip_lo_p0 <= flush_pc_i[1];
      vld_p1     <= 1'b0;
    end else begin
      count_p0 <= count_nxt;
      if (accept && skip_lo_p0) skip_lo_p0 <= 1'b0;
      if (ext_len != 2'd0) begin
        head_pc_p0 <= head_pc_p0 + {{(VADDR-3){1'b0}}, ext_len, 1'b0};
        vld_p1     <= 1'b1;
        inst_p1    <= form_inst(parcel_p0[0], parcel_p0[1], head_comp);
        pc_p1      <= head_pc_p0;
        comp_p1    <= head_comp;
      end else if (inst_ready_i) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign inst_valid_o      = vld_p1;
  assign inst_o            = inst_p1;
  assign inst_pc_o         = pc_p1;
  assign inst_compressed_o = comp_p1;

endmodule

// File: tb/tb_cpu64_inst_aligner.sv
// Self-checking bench for cpu64_inst_aligner: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cpu64_inst_aligner;

  localparam int unsigned VADDR    = 39;
  localparam logic [38:0] RESET_PC = 39'h80000000;

  logic        clk;
  logic        rst_ni;
  logic        fetch_valid_i;
  logic [31:0] fetch_data_i;
  logic        fetch_ready_o;
  logic        flush_i;
  logic [38:0] flush_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [38:0] inst_pc_o;
  logic        inst_compressed_o;

  cpu64_inst_aligner #(.VADDR(VADDR), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .fetch_valid_i(fetch_valid_i), .fetch_data_i(fetch_data_i),
    .fetch_ready_o(fetch_ready_o),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o),
    .inst_compressed_o(inst_compressed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fr_low   = 0;
  logic last_fr;

  logic [31:0] pending[$];

  typedef struct {
    logic [31:0] inst;
    logic [38:0] pc;
    logic        comp;
    int          cyc;
  } del_t;
  del_t dlv[$];

  // Reference model: parcel stream plus output register.
  logic [15:0] mq[$];
  logic [38:0] mpc;
  logic        mskip;
  logic        ov;
  logic [31:0] oi;
  logic [38:0] opc;
  logic        oc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = RESET_PC;
    mskip = RESET_PC[1];
    ov    = 1'b0;
    oi    = 32'h0;
    opc   = '0;
    oc    = 1'b0;
  endtask

  task automatic model_eval(output logic fr, output int len);
    logic [15:0] h;
    len = 0;
    if (!ov || inst_ready_i) begin
      if (mq.size() >= 1) begin
        h = mq[0];
        if (h[1:0] != 2'b11) len = 1;
        else if (mq.size() >= 2) len = 2;
      end
    end
    fr = !flush_i && ((mq.size() - len) <= 1);
  endtask

  task automatic model_step(input logic fr, input int len);
    if (flush_i) begin
      mq.delete();
      mpc   = flush_pc_i;
      mskip = flush_pc_i[1];
      ov    = 1'b0;
    end else begin
      if (len > 0) begin
        oi  = (len == 1) ? {16'h0, mq[0]} : {mq[1], mq[0]};
        opc = mpc;
        oc  = (len == 1);
        ov  = 1'b1;
        for (int k = 0; k < len; k++) void'(mq.pop_front());
        mpc = mpc + 39'(2 * len);
      end else if (inst_ready_i) begin
        ov = 1'b0;
      end
      if (fetch_valid_i && fr) begin
        if (mskip) begin
          mq.push_back(fetch_data_i[31:16]);
          mskip = 1'b0;
        end else begin
          mq.push_back(fetch_data_i[15:0]);
          mq.push_back(fetch_data_i[31:16]);
        end
      end
    end
  endtask

  task automatic chk_out();
    chk("inst_valid", inst_valid_o, ov);
    chk("inst", inst_o, oi);
    chk("inst_pc", inst_pc_o, opc);
    chk("inst_comp", inst_compressed_o, oc);
  endtask

  // One clock: drive at negedge, check handshake, advance model, check outputs.
  task automatic cycle(input logic rdy, input logic fl, input logic [38:0] fpc, input logic gap);
    logic m_fr;
    int   m_len;
    @(negedge clk);
    fetch_valid_i = (pending.size() > 0) && !gap;
    fetch_data_i  = fetch_valid_i ? pending[0] : $urandom;
    inst_ready_i  = rdy;
    flush_i       = fl;
    flush_pc_i    = fpc;
    #1;
    model_eval(m_fr, m_len);
    chk("fetch_ready", fetch_ready_o, m_fr);
    last_fr = fetch_ready_o;
    if (!fetch_ready_o) fr_low++;
    if (inst_valid_o && inst_ready_i)
      dlv.push_back('{inst: inst_o, pc: inst_pc_o, comp: inst_compressed_o, cyc: cyc});
    if (fetch_valid_i && m_fr) void'(pending.pop_front());
    model_step(m_fr, m_len);
    @(posedge clk);
    #1;
    cyc++;
    chk_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_ni        = 1'b0;
    fetch_valid_i = 1'b0;
    flush_i       = 1'b0;
    inst_ready_i  = 1'b0;
    pending.delete();
    model_reset();
    #1;
    chk("rst_valid", inst_valid_o, 1'b0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", inst_pc_o, 39'h0);
    chk("rst_comp", inst_compressed_o, 1'b0);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((pending.size() > 0 || mq.size() > 0 || ov) && n < maxc) begin
      cycle(1'b1, 1'b0, '0, 1'b0);
      n++;
    end
    chk("drain_bound", (pending.size() > 0 || mq.size() > 0 || ov), 1'b0);
  endtask

  task automatic expect_del(input int k, input logic [31:0] i, input logic [38:0] pc, input logic c);
    if (k >= dlv.size()) begin
      chk("del_missing", k, dlv.size());
    end else begin
      chk("del_inst", dlv[k].inst, i);
      chk("del_pc", dlv[k].pc, pc);
      chk("del_comp", dlv[k].comp, c);
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [15:0] a;
    logic [15:0] b;
    a = 16'($urandom);
    b = 16'($urandom);
    if ($urandom % 2 == 0) a[1:0] = 2'b11;
    if ($urandom % 2 == 0) b[1:0] = 2'b11;
    return {b, a};
  endfunction

  initial begin
    logic [38:0] f;
    int n;
    rst_ni        = 1'b0;
    fetch_valid_i = 1'b0;
    fetch_data_i  = 32'h0;
    flush_i       = 1'b0;
    flush_pc_i    = '0;
    inst_ready_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Aligned 32-bit stream, back-to-back.
    pending.push_back(32'h00100093);
    pending.push_back(32'h00200113);
    pending.push_back(32'h00300193);
    dlv.delete();
    drain(20);
    chk("al_count", dlv.size(), 3);
    expect_del(0, 32'h00100093, 39'h80000000, 1'b0);
    expect_del(1, 32'h00200113, 39'h80000004, 1'b0);
    expect_del(2, 32'h00300193, 39'h80000008, 1'b0);
    if (dlv.size() == 3) begin
      chk("al_consec1", dlv[1].cyc - dlv[0].cyc, 1);
      chk("al_consec2", dlv[2].cyc - dlv[1].cyc, 1);
    end

    // Two compressed instructions in one word.
    do_reset();
    pending.push_back(32'h45054501);
    dlv.delete();
    fr_low = 0;
    drain(20);
    chk("c2_count", dlv.size(), 2);
    expect_del(0, 32'h00004501, 39'h80000000, 1'b1);
    expect_del(1, 32'h00004505, 39'h80000002, 1'b1);
    chk("c2_fr_low", fr_low, 0);

    // Straddling 32-bit instruction.
    do_reset();
    pending.push_back(32'h00934501);
    pending.push_back(32'h45010010);
    dlv.delete();
    drain(20);
    chk("st_count", dlv.size(), 3);
    expect_del(0, 32'h00004501, 39'h80000000, 1'b1);
    expect_del(1, 32'h00100093, 39'h80000002, 1'b0);
    expect_del(2, 32'h00004501, 39'h80000006, 1'b1);

    // Backpressure during a compressed stream.
    do_reset();
    for (int i = 0; i < 4; i++) pending.push_back(32'h45054501);
    dlv.delete();
    cycle(1'b1, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    fr_low = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      chk("bp_hold_valid", inst_valid_o, 1'b1);
      chk("bp_hold_inst", inst_o, 32'h00004501);
      chk("bp_hold_pc", inst_pc_o, 39'h80000000);
    end
    chk("bp_fr_dropped", fr_low > 0, 1'b1);
    drain(40);
    chk("bp_count", dlv.size(), 8);
    for (int i = 0; i < 8; i++)
      expect_del(i, (i % 2) ? 32'h00004505 : 32'h00004501, 39'h80000000 + 39'(2 * i), 1'b1);

    // Misaligned redirect.
    cycle(1'b1, 1'b1, 39'h80000102, 1'b0);
    pending.push_back(32'h45054501);
    dlv.delete();
    drain(20);
    chk("mr_count", dlv.size(), 1);
    expect_del(0, 32'h00004505, 39'h80000102, 1'b1);

    // Flush while stalled with a word presented.
    do_reset();
    pending.push_back(32'h00100093);
    n = 0;
    while (!inst_valid_o && n < 10) begin
      cycle(1'b0, 1'b0, '0, 1'b0);
      n++;
    end
    chk("fs_valid_before", inst_valid_o, 1'b1);
    pending.push_back(32'h00200113);
    cycle(1'b0, 1'b1, 39'h80000200, 1'b0);
    chk("fs_fr", last_fr, 1'b0);
    chk("fs_valid_after", inst_valid_o, 1'b0);
    chk("fs_word_kept", pending.size(), 1);
    dlv.delete();
    drain(20);
    chk("fs_count", dlv.size(), 1);
    expect_del(0, 32'h00200113, 39'h80000200, 1'b0);

    // PC wrap at the top of the address space.
    cycle(1'b1, 1'b1, 39'h7FFFFFFFFC, 1'b0);
    pending.push_back(32'h00100093);
    pending.push_back(32'h45014501);
    dlv.delete();
    drain(20);
    chk("wr_count", dlv.size(), 3);
    expect_del(0, 32'h00100093, 39'h7FFFFFFFFC, 1'b0);
    expect_del(1, 32'h00004501, 39'h0000000000, 1'b1);
    expect_del(2, 32'h00004501, 39'h0000000002, 1'b1);

    // Randomized traffic with redirects, backpressure, gaps and resets.
    for (int i = 0; i < 3000; i++) begin
      if (pending.size() < 2 && ($urandom % 4) != 0) pending.push_back(rand_word());
      if (($urandom % 500) == 0) begin
        do_reset();
      end else begin
        f = 39'({$urandom, $urandom});
        f[0] = 1'b0;
        cycle(($urandom % 4) != 0, ($urandom % 40) == 0, f, ($urandom % 5) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
